// File: rtl/exe_alu.sv
`default_nettype none
// ============================================================================
// Module   : exe_alu
// Brief    : EXE-stage 32-bit integer ALU with registered result, N/Z/C/V
//            flags and a one-cycle valid qualifier. Optional multiply ops are
//            enabled by defining the ALU_MUL_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module exe_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      alu_ctrl,
   output logic [XLEN-1:0] result,
   output logic            N,
   output logic            Z,
   output logic            C,
   output logic            V,
   output logic            out_valid
);

   localparam logic [4:0] c_op_add   = 5'b00000;
   localparam logic [4:0] c_op_sub   = 5'b00001;
   localparam logic [4:0] c_op_and   = 5'b00010;
   localparam logic [4:0] c_op_or    = 5'b00011;
   localparam logic [4:0] c_op_xor   = 5'b00100;
   localparam logic [4:0] c_op_sll   = 5'b00101;
   localparam logic [4:0] c_op_srl   = 5'b00110;
   localparam logic [4:0] c_op_sra   = 5'b00111;
   localparam logic [4:0] c_op_slt   = 5'b01000;
   localparam logic [4:0] c_op_sltu  = 5'b01001;
   localparam logic [4:0] c_op_passb = 5'b01010;
`ifdef ALU_MUL_EN
   localparam logic [4:0] c_op_mul   = 5'b01011;
   localparam logic [4:0] c_op_mulh  = 5'b01100;
   localparam logic [4:0] c_op_mulhu = 5'b01101;
`endif

   logic [XLEN-1:0] r_result;
   logic            r_n;
   logic            r_z;
   logic            r_c;
   logic            r_v;
   logic            r_out_valid;

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_diff;
   logic            w_add_v;
   logic            w_sub_v;
   logic            w_slt;
   logic            w_sltu;
   logic [4:0]      w_shamt;
   logic [XLEN-1:0] w_res;
   logic            w_c;
   logic            w_v;

   // Shared adder/subtractor; SLT/SLTU are derived from the subtract path.
   assign w_sum   = {1'b0, a} + {1'b0, b};
   assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
   assign w_add_v = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1]  != a[XLEN-1]);
   assign w_sub_v = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
   assign w_slt   = w_diff[XLEN-1] ^ w_sub_v;
   assign w_sltu  = ~w_diff[XLEN];
   assign w_shamt = b[4:0];

`ifdef ALU_MUL_EN
   // One signed multiplier; the unsigned high word is recovered by adding back
   // each operand wherever the other one had its sign bit set.
   logic signed [2*XLEN-1:0] w_prod;
   logic        [XLEN-1:0]   w_mulhu;

   assign w_prod  = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
   assign w_mulhu = w_prod[2*XLEN-1:XLEN]
                  + (a[XLEN-1] ? b : {XLEN{1'b0}})
                  + (b[XLEN-1] ? a : {XLEN{1'b0}});
`endif

   // Operation select: result plus carry/overflow (only ADD/SUB set C/V).
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (alu_ctrl)
         c_op_add: begin
            w_res = w_sum[XLEN-1:0];
            w_c   = w_sum[XLEN];
            w_v   = w_add_v;
         end
         c_op_sub: begin
            w_res = w_diff[XLEN-1:0];
            w_c   = w_diff[XLEN];
            w_v   = w_sub_v;
         end
         c_op_and:   w_res = a & b;
         c_op_or:    w_res = a | b;
         c_op_xor:   w_res = a ^ b;
         c_op_sll:   w_res = a << w_shamt;
         c_op_srl:   w_res = a >> w_shamt;
         c_op_sra:   w_res = $signed(a) >>> w_shamt;
         c_op_slt:   w_res = {{(XLEN-1){1'b0}}, w_slt};
         c_op_sltu:  w_res = {{(XLEN-1){1'b0}}, w_sltu};
         c_op_passb: w_res = b;
`ifdef ALU_MUL_EN
         c_op_mul:   w_res = w_prod[XLEN-1:0];
         c_op_mulh:  w_res = w_prod[2*XLEN-1:XLEN];
         c_op_mulhu: w_res = w_mulhu;
`endif
         default:    w_res = '0;
      endcase
   end

   // Output register: loads on valid input, holds otherwise, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_v         <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_result <= w_res;
            r_n      <= w_res[XLEN-1];
            r_z      <= (w_res == '0);
            r_c      <= w_c;
            r_v      <= w_v;
         end
      end
   end

   assign result    = r_result;
   assign N         = r_n;
   assign Z         = r_z;
   assign C         = r_c;
   assign V         = r_v;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_exe_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_alu
// Brief    : Self-checking bench for exe_alu: directed cases plus randomized
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  alu_ctrl;
   logic [31:0] result;
   logic        N, Z, C, V;
   logic        out_valid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        n;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   exp_t last;

   always #5 clk = ~clk;

   exe_alu #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .alu_ctrl (alu_ctrl),
      .result   (result),
      .N        (N),
      .Z        (Z),
      .C        (C),
      .V        (V),
      .out_valid(out_valid)
   );

   // Reference model in plain 64-bit integer arithmetic.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [4:0] op);
      longint          sa;
      longint          sb;
      longint          s;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned u;
      logic [31:0]     r;
      logic            c;
      logic            v;
      exp_t            e;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      ua = longint'(ma);
      ub = longint'(mb);
      r  = '0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         5'd0: begin
            s = sa + sb;
            u = ua + ub;
            r = u[31:0];
            c = (u >= 64'h1_0000_0000);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd1: begin
            s = sa - sb;
            r = ma - mb;
            c = (ma >= mb);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd2:  r = ma & mb;
         5'd3:  r = ma | mb;
         5'd4:  r = ma ^ mb;
         5'd5:  r = ma << mb[4:0];
         5'd6:  r = ma >> mb[4:0];
         5'd7:  r = $signed(ma) >>> mb[4:0];
         5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
         5'd10: r = mb;
`ifdef ALU_MUL_EN
         5'd11: begin s = sa * sb; r = s[31:0];  end
         5'd12: begin s = sa * sb; r = s[63:32]; end
         5'd13: begin u = ua * ub; r = u[63:32]; end
`endif
         default: r = '0;
      endcase
      e.res = r;
      e.n   = r[31];
      e.z   = (r == 32'd0);
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic exp_valid);
      chk({tag, "_res"},   result,           last.res);
      chk({tag, "_N"},     {31'd0, N},       {31'd0, last.n});
      chk({tag, "_Z"},     {31'd0, Z},       {31'd0, last.z});
      chk({tag, "_C"},     {31'd0, C},       {31'd0, last.c});
      chk({tag, "_V"},     {31'd0, V},       {31'd0, last.v});
      chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
   endtask

   // Issue one op, then check it one edge later.
   task automatic exec(input logic [31:0] ea, input logic [31:0] eb,
                       input logic [4:0] op, input string tag);
      @(negedge clk);
      in_valid = 1'b1;
      a        = ea;
      b        = eb;
      alu_ctrl = op;
      last     = model(ea, eb, op);
      @(posedge clk);
      #1;
      chk_all(tag, 1'b1);
   endtask

   // Idle cycle with junk operands: outputs must hold, valid drops.
   task automatic idle(input string tag);
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      alu_ctrl = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      chk_all(tag, 1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] edges [8];
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                32'h8000_0000, 32'h8000_0001, 32'h0000_001F, 32'hF000_0000};
      if ($urandom_range(0, 3) == 0)
         return edges[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   initial begin
      // Reset held with a valid op present: everything must stay cleared.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1234_5678;
      alu_ctrl = 5'd0;
      last     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0);

      rst_n = 1'b1;
      exec(32'hF000_0000, 32'h9000_0000, 5'd0, "add_neg");
      chk("add_neg_lit", result, 32'h8000_0000);
      exec(32'hF000_0000, 32'h9000_0000, 5'd1, "sub_neg");
      chk("sub_neg_lit", result, 32'h6000_0000);
      exec(32'hF000_0000, 32'h9000_0000, 5'd8, "slt_neg");
      exec(32'hF000_0000, 32'h9000_0000, 5'd9, "sltu_neg");

      exec(32'h0, 32'h0, 5'd0, "add_zero");
      exec(32'h0, 32'h0, 5'd1, "sub_zero");
      chk("sub_zero_C_lit", {31'd0, C}, 32'd1);
      for (int op = 2; op <= 7; op++) exec(32'h0, 32'h0, 5'(op), "logic_zero");

      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd2, "and");
      chk("and_lit", result, 32'h0000_00FF);
      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd3, "or");
      chk("or_lit", result, 32'hF044_0FFF);
      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd4, "xor");
      chk("xor_lit", result, 32'hF044_0F00);
      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd5, "sll31");
      chk("sll31_lit", result, 32'h8000_0000);
      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd6, "srl31");
      exec(32'h0044_00FF, 32'hF000_0FFF, 5'd7, "sra31");
      exec(32'h0000_0419, 32'h0004_0004, 5'd5, "sll4");
      chk("sll4_lit", result, 32'h0000_4190);
      exec(32'hF00F_FFFF, 32'h8000_8000, 5'd6, "srl0");
      exec(32'hF00F_FFFF, 32'h8000_8000, 5'd7, "sra0");
      chk("sra0_lit", result, 32'hF00F_FFFF);

      exec(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, "add_ovf");
      chk("add_ovf_V_lit", {31'd0, V}, 32'd1);
      exec(32'h8000_0000, 32'h0000_0001, 5'd1, "sub_ovf");
      chk("sub_ovf_lit", result, 32'h7FFF_FFFF);
      exec(32'h8000_0000, 32'h0000_0001, 5'd8, "slt_ovf");
      chk("slt_ovf_lit", result, 32'h0000_0001);
      idle("hold");
      exec(32'h1234_5678, 32'hCAFE_0000, 5'd10, "passb");
      exec(32'h1234_5678, 32'hCAFE_0000, 5'd31, "unsup");
      exec(32'h1234_5678, 32'hCAFE_0000, 5'd11, "mul_code");

      // Reset while an op is being presented discards it.
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 32'hFFFF_FFFF;
      b        = 32'h1;
      alu_ctrl = 5'd0;
      last     = '0;
      @(posedge clk);
      #1;
      chk_all("midreset", 1'b0);
      rst_n = 1'b1;
      exec(32'h5, 32'h3, 5'd1, "after_reset");

      // Randomized traffic, including unsupported codes and idle gaps.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0)
            idle("rnd_idle");
         else
            exec(pick_operand(), pick_operand(), 5'($urandom_range(0, 15)), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
